// File: rtl/munoc_link_elastic_buffer.sv
// Flit elastic buffer in front of a router input port: registered-state ready,
// optional store-and-forward release, and upstream head/tail framing checks.
module munoc_link_elastic_buffer #(
  parameter int unsigned BW_PHIT   = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned STORE_FWD = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_head,
  input  logic                         in_tail,
  input  logic [BW_PHIT-1:0]           in_phit,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_head,
  output logic                         out_tail,
  output logic [BW_PHIT-1:0]           out_phit,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [$clog2(DEPTH+1)-1:0]   pkt_count,
  input  logic                         err_clear,
  output logic                         err_protocol
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_SEND = 1'b1} state_e;

  logic               head_mem_q [DEPTH];
  logic               tail_mem_q [DEPTH];
  logic [BW_PHIT-1:0] phit_mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [CW-1:0] pkt_q, pkt_d;
  logic          open_q, open_d;
  logic          err_q, err_d;
  state_e        state_q, state_d;

  logic               full_s, empty_s;
  logic               wr_en_s, rd_en_s;
  logic               out_valid_s;
  logic               rd_head_s, rd_tail_s;
  logic [BW_PHIT-1:0] rd_phit_s;
  logic               frame_err_s;

  assign full_s    = (occ_q == CW'(DEPTH));
  assign empty_s   = (occ_q == {CW{1'b0}});
  assign in_ready  = !full_s & !rst;
  assign wr_en_s   = in_valid & in_ready;
  assign rd_en_s   = out_valid_s & out_ready;

  assign rd_head_s = head_mem_q[rd_ptr_q];
  assign rd_tail_s = tail_mem_q[rd_ptr_q];
  assign rd_phit_s = phit_mem_q[rd_ptr_q];

  // Gate the presented flit so an idle output always reads as all-zero.
  assign out_valid    = out_valid_s;
  assign out_head     = out_valid_s & rd_head_s;
  assign out_tail     = out_valid_s & rd_tail_s;
  assign out_phit     = out_valid_s ? rd_phit_s : {BW_PHIT{1'b0}};
  assign occupancy    = occ_q;
  assign pkt_count    = pkt_q;
  assign err_protocol = err_q;

  // A head is only legal outside a packet, a non-head only inside one.
  assign frame_err_s = wr_en_s & (in_head == open_q);

  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      head_mem_q[wr_ptr_q] <= in_head;
      tail_mem_q[wr_ptr_q] <= in_tail;
      phit_mem_q[wr_ptr_q] <= in_phit;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    occ_d = occ_q + CW'(wr_en_s) - CW'(rd_en_s);
    pkt_d = pkt_q + CW'(wr_en_s & in_tail) - CW'(rd_en_s & rd_tail_s);
  end

  always_comb begin
    open_d = open_q;
    err_d  = err_q;
    if (wr_en_s) begin
      if (in_tail) begin
        open_d = 1'b0;
      end else if (in_head) begin
        open_d = 1'b1;
      end else begin
        open_d = open_q;
      end
    end else begin
      open_d = open_q;
    end
    // A fresh error outranks a simultaneous clear.
    if (frame_err_s) begin
      err_d = 1'b1;
    end else if (err_clear) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      occ_q    <= {CW{1'b0}};
      pkt_q    <= {CW{1'b0}};
      open_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      pkt_q    <= pkt_d;
      open_q   <= open_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (rd_en_s & !rd_tail_s) begin
          state_d = S_SEND;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (rd_en_s & rd_tail_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_SEND;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Full buffer in IDLE forces cut-through so packets longer than DEPTH drain.
  always_comb begin
    out_valid_s = 1'b0;
    if (rst) begin
      out_valid_s = 1'b0;
    end else if (STORE_FWD == 0) begin
      out_valid_s = !empty_s;
    end else begin
      case (state_q)
        S_IDLE:  out_valid_s = !empty_s & ((pkt_q != {CW{1'b0}}) | full_s);
        S_SEND:  out_valid_s = !empty_s;
        default: out_valid_s = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_munoc_link_elastic_buffer.sv
// Randomized bench: a cut-through and a store-and-forward instance, each
// checked every cycle against a queue-based model of the buffer rules.
module tb_munoc_link_elastic_buffer;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       in_valid [2];
  logic       in_ready [2];
  logic       in_head [2];
  logic       in_tail [2];
  logic [7:0] in_phit [2];
  logic       out_valid [2];
  logic       out_ready [2];
  logic       out_head [2];
  logic       out_tail [2];
  logic [7:0] out_phit [2];
  logic [2:0] occupancy [2];
  logic [2:0] pkt_count [2];
  logic       err_clear [2];
  logic       err_protocol [2];

  int n_chk = 0;
  int n_err = 0;

  // Model state: flit = {head, tail, phit}
  logic [9:0] q0 [$];
  logic [9:0] q1 [$];
  bit sending [2];
  bit open_m [2];
  bit err_m [2];
  bit gen_open [2];
  bit hold [2];

  munoc_link_elastic_buffer #(.BW_PHIT(8), .DEPTH(DEPTH), .STORE_FWD(0)) u_ct (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_head(in_head[0]),
    .in_tail(in_tail[0]), .in_phit(in_phit[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_head(out_head[0]),
    .out_tail(out_tail[0]), .out_phit(out_phit[0]),
    .occupancy(occupancy[0]), .pkt_count(pkt_count[0]),
    .err_clear(err_clear[0]), .err_protocol(err_protocol[0])
  );

  munoc_link_elastic_buffer #(.BW_PHIT(8), .DEPTH(DEPTH), .STORE_FWD(1)) u_sf (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_head(in_head[1]),
    .in_tail(in_tail[1]), .in_phit(in_phit[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_head(out_head[1]),
    .out_tail(out_tail[1]), .out_phit(out_phit[1]),
    .occupancy(occupancy[1]), .pkt_count(pkt_count[1]),
    .err_clear(err_clear[1]), .err_protocol(err_protocol[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int qsize(int m);
    return (m == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [9:0] qfront(int m);
    return (m == 0) ? q0[0] : q1[0];
  endfunction

  function automatic int tail_count(int m);
    int n = 0;
    for (int i = 0; i < qsize(m); i++) begin
      if (m == 0) n += int'(q0[i][8]);
      else        n += int'(q1[i][8]);
    end
    return n;
  endfunction

  function automatic void qpush(int m, logic [9:0] v);
    if (m == 0) q0.push_back(v);
    else        q1.push_back(v);
  endfunction

  function automatic void qpop(int m);
    if (m == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endfunction

  function automatic void qclear(int m);
    if (m == 0) q0.delete();
    else        q1.delete();
  endfunction

  initial begin
    int pct;
    rst = 1'b1;
    for (int m = 0; m < 2; m++) begin
      in_valid[m] = 1'b0; in_head[m] = 1'b0; in_tail[m] = 1'b0; in_phit[m] = 8'h00;
      out_ready[m] = 1'b0; err_clear[m] = 1'b0;
      sending[m] = 1'b0; open_m[m] = 1'b0; err_m[m] = 1'b0;
      gen_open[m] = 1'b0; hold[m] = 1'b0;
    end
    @(posedge clk); #1;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      rst = (cyc < 3) || ($urandom_range(0, 299) == 0);
      case ((cyc / 250) % 4)
        0:       pct = 100;
        1:       pct = 60;
        2:       pct = 15;
        default: pct = 85;
      endcase
      for (int m = 0; m < 2; m++) begin
        out_ready[m] = ($urandom_range(0, 99) < pct);
        err_clear[m] = ($urandom_range(0, 19) == 0);
        if (!hold[m]) begin
          in_valid[m] = ($urandom_range(0, 3) != 0);
          in_head[m]  = !gen_open[m];
          in_tail[m]  = ($urandom_range(0, 3) == 0);
          in_phit[m]  = 8'($urandom);
          if ($urandom_range(0, 39) == 0) in_head[m] = !in_head[m];
        end
      end

      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        int sz;
        bit full, e_ir, e_ov, wr, rd, bad;
        logic [9:0] fr, e_out;
        string pfx;
        pfx  = (m == 0) ? "ct" : "sf";
        sz   = qsize(m);
        full = (sz == DEPTH);
        fr   = (sz > 0) ? qfront(m) : 10'h000;
        if (rst) begin
          e_ir = 1'b0;
          e_ov = 1'b0;
        end else begin
          e_ir = !full;
          if (m == 0)          e_ov = (sz > 0);
          else if (sending[m]) e_ov = (sz > 0);
          else                 e_ov = (sz > 0) && ((tail_count(m) > 0) || full);
        end
        e_out = e_ov ? fr : 10'h000;

        chk({pfx, "_in_ready"}, 32'(in_ready[m]), 32'(e_ir));
        chk({pfx, "_out_valid"}, 32'(out_valid[m]), 32'(e_ov));
        chk({pfx, "_out_flit"}, 32'({out_head[m], out_tail[m], out_phit[m]}), 32'(e_out));
        chk({pfx, "_occupancy"}, 32'(occupancy[m]), 32'(sz));
        chk({pfx, "_pkt_count"}, 32'(pkt_count[m]), 32'(tail_count(m)));
        chk({pfx, "_err_protocol"}, 32'(err_protocol[m]), 32'(err_m[m]));
        chk({pfx, "_occ_bound"}, 32'(occupancy[m] <= 3'(DEPTH)), 32'd1);
        chk({pfx, "_pkt_bound"}, 32'(pkt_count[m] <= occupancy[m]), 32'd1);

        if (rst) begin
          qclear(m);
          sending[m] = 1'b0; open_m[m] = 1'b0; err_m[m] = 1'b0;
          gen_open[m] = 1'b0; hold[m] = 1'b0;
        end else begin
          rd = e_ov && out_ready[m];
          wr = in_valid[m] && e_ir;
          bad = wr && (in_head[m] == open_m[m]);
          err_m[m] = bad || (err_m[m] && !err_clear[m]);
          if (wr) begin
            if (in_tail[m])      open_m[m] = 1'b0;
            else if (in_head[m]) open_m[m] = 1'b1;
            gen_open[m] = open_m[m];
          end
          if (rd) begin
            sending[m] = !fr[8];
            qpop(m);
          end
          if (wr) qpush(m, {in_head[m], in_tail[m], in_phit[m]});
          hold[m] = in_valid[m] && !wr;
        end
      end
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
